// File: rtl/data_memory_pkg.sv
// ============================================================================
// data_memory_pkg : shared encodings, widths and store-replication helper
// Rev 1.0
// ============================================================================
`default_nettype none

package data_memory_pkg;

  localparam int DATA_W = 32;
  localparam int WE_W   = 4;

  typedef enum logic [2:0] {
    LD_WORD  = 3'b000,
    LD_UBYTE = 3'b001,
    LD_SBYTE = 3'b010,
    LD_UHALF = 3'b011,
    LD_SHALF = 3'b100
  } ld_sel_e;

  typedef enum logic [1:0] {
    ST_WORD = 2'b00,
    ST_BYTE = 2'b01,
    ST_HALF = 2'b10
  } st_sel_e;

  // Replicate the right-justified store data so every byte lane carries the
  // value to be written; the lane enables then pick which lanes land.
  function automatic logic [DATA_W-1:0] store_replicate(
    input logic [DATA_W-1:0] wd,
    input logic [1:0]        sel
  );
    logic [DATA_W-1:0] res;
    case (sel)
      ST_BYTE: res = {4{wd[7:0]}};
      ST_HALF: res = {2{wd[15:0]}};
      default: res = wd;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_memory_load_align.sv
// ============================================================================
// data_memory_load_align : combinational lane select and zero/sign extension
// Rev 1.0
// ============================================================================
`default_nettype none

module data_memory_load_align
  import data_memory_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        addr,
  input  logic [2:0]        select,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? word[31:16] : word[15:0];
    case (select)
      LD_UBYTE: result = {24'h0, byte_sel};
      LD_SBYTE: result = {{24{byte_sel[7]}}, byte_sel};
      LD_UHALF: result = {16'h0, half_sel};
      LD_SHALF: result = {{16{half_sel[15]}}, half_sel};
      default:  result = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
// data_memory : byte-lane flop memory with formatted registered load and swap
// Rev 1.0
// ============================================================================
`default_nettype none

module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [31:0]       addr_in,
  input  logic [WE_W-1:0]   we_in,
  input  logic [DATA_W-1:0] wd_in,
  input  logic              swp_ctrl_in,
  input  logic [2:0]        ctrl_load_mux_in,
  input  logic [1:0]        ctrl_str_mux_in,
  output logic [DATA_W-1:0] rd_out
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_d;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] ld_result;
  logic              unused_addr;

  // Upper address bits drop out, so accesses wrap modulo DEPTH words.
  assign word_idx    = addr_in[IDX_W+1:2];
  assign unused_addr = &{1'b0, addr_in[31:IDX_W+2]};
  assign st_data     = store_replicate(wd_in, ctrl_str_mux_in);

  data_memory_load_align u_load_align (
    .word   (mem_q[word_idx]),
    .addr   (addr_in[1:0]),
    .select (ctrl_load_mux_in),
    .result (ld_result)
  );

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    for (int i = 0; i < WE_W; i++) begin
      if (we_in[i]) mem_d[word_idx][8*i +: 8] = st_data[8*i +: 8];
    end
    // Load path sees the pre-write word, which makes a swap atomic.
    if ((we_in == '0) || swp_ctrl_in) rd_d = ld_result;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

  assign rd_out = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_data_memory.sv
// ============================================================================
// tb_data_memory : directed vector bench for data_memory
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_data_memory;

  logic        clk_in;
  logic        reset_in;
  logic [31:0] addr_in;
  logic [3:0]  we_in;
  logic [31:0] wd_in;
  logic        swp_ctrl_in;
  logic [2:0]  ctrl_load_mux_in;
  logic [1:0]  ctrl_str_mux_in;
  logic [31:0] rd_out;

  int n_vec = 0;
  int n_err = 0;

  data_memory #(.DEPTH(256)) dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .addr_in          (addr_in),
    .we_in            (we_in),
    .wd_in            (wd_in),
    .swp_ctrl_in      (swp_ctrl_in),
    .ctrl_load_mux_in (ctrl_load_mux_in),
    .ctrl_str_mux_in  (ctrl_str_mux_in),
    .rd_out           (rd_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wd;
    logic        swp;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd,
                     input logic swp, input logic [2:0] ld, input logic [1:0] st,
                     input logic [31:0] exp);
    vec_t v;
    v.addr = addr; v.we = we; v.wd = wd; v.swp = swp; v.ld = ld; v.st = st; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: rd_out=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive between edges, clock once, sample just after the rising edge.
  task automatic apply(input vec_t v, input string name);
    @(negedge clk_in);
    addr_in = v.addr; we_in = v.we; wd_in = v.wd; swp_ctrl_in = v.swp;
    ctrl_load_mux_in = v.ld; ctrl_str_mux_in = v.st;
    @(posedge clk_in);
    #1;
    check(name, rd_out, v.exp);
  endtask

  task automatic read_word(input logic [31:0] addr, input logic [31:0] exp, input string name);
    vec_t v;
    v.addr = addr; v.we = 4'b0000; v.wd = 32'h0; v.swp = 1'b0;
    v.ld = 3'b000; v.st = 2'b00; v.exp = exp;
    apply(v, name);
  endtask

  initial begin
    reset_in = 1'b0; addr_in = '0; we_in = '0; wd_in = '0;
    swp_ctrl_in = 1'b0; ctrl_load_mux_in = '0; ctrl_str_mux_in = '0;

    //   addr           we       wd            swp   ld      st     expected rd_out
    add(32'h0000_0000, 4'b0000, 32'h0,        1'b0, 3'b000, 2'b00, 32'h0000_0000);
    add(32'h0000_0010, 4'b1111, 32'h80FF7F01, 1'b0, 3'b000, 2'b00, 32'h0000_0000);
    add(32'h0000_0013, 4'b0000, 32'h0,        1'b0, 3'b010, 2'b00, 32'hFFFF_FF80);
    add(32'h0000_0013, 4'b0000, 32'h0,        1'b0, 3'b001, 2'b00, 32'h0000_0080);
    add(32'h0000_0012, 4'b0000, 32'h0,        1'b0, 3'b100, 2'b00, 32'hFFFF_80FF);
    add(32'h0000_0012, 4'b0000, 32'h0,        1'b0, 3'b011, 2'b00, 32'h0000_80FF);
    add(32'h0000_0013, 4'b0000, 32'h0,        1'b0, 3'b100, 2'b00, 32'hFFFF_80FF);
    add(32'h0000_0011, 4'b0000, 32'h0,        1'b0, 3'b011, 2'b00, 32'h0000_7F01);
    add(32'h0000_0010, 4'b0000, 32'h0,        1'b0, 3'b010, 2'b00, 32'h0000_0001);
    add(32'h0000_0011, 4'b0000, 32'h0,        1'b0, 3'b010, 2'b00, 32'h0000_007F);
    add(32'h0000_0012, 4'b0000, 32'h0,        1'b0, 3'b001, 2'b00, 32'h0000_00FF);
    add(32'h0000_0012, 4'b0000, 32'h0,        1'b0, 3'b010, 2'b00, 32'hFFFF_FFFF);
    add(32'h0000_0010, 4'b0000, 32'h0,        1'b0, 3'b101, 2'b00, 32'h80FF_7F01);
    add(32'h0000_0011, 4'b0000, 32'h0,        1'b0, 3'b111, 2'b00, 32'h80FF_7F01);
    add(32'h0000_0020, 4'b1111, 32'h11223344, 1'b0, 3'b000, 2'b00, 32'h80FF_7F01);
    add(32'h0000_0021, 4'b0010, 32'h0000_00AB, 1'b0, 3'b000, 2'b01, 32'h80FF_7F01);
    add(32'h0000_0020, 4'b0000, 32'h0,        1'b0, 3'b000, 2'b00, 32'h1122_AB44);
    add(32'h0000_0022, 4'b1100, 32'h0000_BEEF, 1'b0, 3'b000, 2'b10, 32'h1122_AB44);
    add(32'h0000_0020, 4'b0000, 32'h0,        1'b0, 3'b000, 2'b00, 32'hBEEF_AB44);
    add(32'h0000_0030, 4'b0101, 32'hCAFE_F00D, 1'b0, 3'b000, 2'b11, 32'hBEEF_AB44);
    add(32'h0000_0030, 4'b0000, 32'h0,        1'b0, 3'b000, 2'b00, 32'h00FE_000D);
    add(32'h0000_0410, 4'b0000, 32'h0,        1'b0, 3'b000, 2'b00, 32'h80FF_7F01);
    add(32'hFFFF_FC13, 4'b0000, 32'h0,        1'b0, 3'b001, 2'b00, 32'h0000_0080);
    add(32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 1'b1, 3'b000, 2'b00, 32'h80FF_7F01);
    add(32'h0000_0010, 4'b0000, 32'h0,        1'b0, 3'b000, 2'b00, 32'hDEAD_BEEF);
    add(32'h0000_0023, 4'b1000, 32'h0000_0077, 1'b1, 3'b010, 2'b01, 32'hFFFF_FFBE);
    add(32'h0000_0020, 4'b0000, 32'h0,        1'b0, 3'b000, 2'b00, 32'h77EF_AB44);

    repeat (3) @(posedge clk_in);
    #1;
    check("reset_rd_out", rd_out, 32'h0);
    @(negedge clk_in);
    reset_in = 1'b1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a cycle while a write is pending.
    read_word(32'h0000_0010, 32'hDEAD_BEEF, "pre_reset_read");
    @(negedge clk_in);
    addr_in = 32'h0000_0040; we_in = 4'b1111; wd_in = 32'h1234_5678;
    swp_ctrl_in = 1'b0; ctrl_load_mux_in = 3'b000; ctrl_str_mux_in = 2'b00;
    #2 reset_in = 1'b0;
    #1 check("async_reset_rd_out", rd_out, 32'h0);
    @(posedge clk_in);
    #1 check("reset_held_rd_out", rd_out, 32'h0);
    @(negedge clk_in);
    we_in = 4'b0000;
    reset_in = 1'b1;

    for (int a = 0; a < 256; a++) read_word(32'(a * 4), 32'h0, $sformatf("cleared_word%0d", a));

    begin
      vec_t v;
      v.addr = 32'h0000_0040; v.we = 4'b1111; v.wd = 32'h1234_5678; v.swp = 1'b0;
      v.ld = 3'b000; v.st = 2'b00; v.exp = 32'h0;
      apply(v, "post_reset_write_hold");
    end
    read_word(32'h0000_0040, 32'h1234_5678, "post_reset_readback");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The parameter DEPTH SHALL default to 256 and SHALL give the number of 32-bit words.
REQ-002 clk_in  input  1  single clock; all state updates occur on its rising edge.
REQ-003 reset_in  input  1  reset, asynchronous and active-low.
REQ-004 addr_in  input  32  byte address; word index is addr_in[9:2], lane select is addr_in[1:0], bits [31:10] are ignored.
REQ-005 we_in  input  4  byte-lane write enables; bit i enables byte lane i (bits [8i+7:8i]).
REQ-006 wd_in  input  32  store data, right-justified.
REQ-007 swp_ctrl_in  input  1  swap: read old word and write new data in the same cycle.
REQ-008 ctrl_load_mux_in  input  3  load format select.
REQ-009 ctrl_str_mux_in  input  2  store format select.
REQ-010 rd_out  output  32  registered, formatted load data.

Function
REQ-011 The memory SHALL be a flop array of DEPTH x 32 bits, little-endian (lane 0 = bits [7:0]).
REQ-012 Store replication SHALL be: ctrl_str_mux_in 00 = wd_in unchanged; 01 = wd_in[7:0] replicated to all 4 lanes; 10 = wd_in[15:0] replicated to both halves; 11 = treated as 00.
REQ-013 On each rising edge, every lane i with we_in[i]=1 SHALL be written with lane i of the replicated store data; lanes with we_in[i]=0 SHALL be unchanged.
REQ-014 Load formatting SHALL act on the addressed word read before any same-edge write.
REQ-015 ctrl_load_mux_in 000 SHALL select the full word.
REQ-016 ctrl_load_mux_in 001 SHALL select the byte at lane addr_in[1:0], zero-extended.
REQ-017 ctrl_load_mux_in 010 SHALL select the byte at lane addr_in[1:0], sign-extended.
REQ-018 ctrl_load_mux_in 011 SHALL select the halfword at addr_in[1] (0 = low), zero-extended.
REQ-019 ctrl_load_mux_in 100 SHALL select the halfword at addr_in[1] (0 = low), sign-extended.
REQ-020 ctrl_load_mux_in 101 to 111 SHALL be treated as 000.
REQ-021 rd_out SHALL be registered: the formatted read of the address presented at edge N SHALL appear after edge N (one-cycle latency).
REQ-022 When we_in = 0000, rd_out SHALL update every cycle with the formatted read.
REQ-023 When we_in != 0000 and swp_ctrl_in = 0, rd_out SHALL hold its previous value.
REQ-024 When we_in != 0000 and swp_ctrl_in = 1, rd_out SHALL capture the formatted old contents and the write SHALL occur on the same edge (read-before-write, atomic swap).
REQ-025 Halfword accesses SHALL ignore addr_in[0].
REQ-026 Misaligned accesses SHALL NOT raise an error or change behaviour beyond REQ-016 to REQ-019 and REQ-025.
REQ-027 Addresses SHALL wrap modulo DEPTH words; no out-of-range error SHALL be raised.

Reset
REQ-028 Asserting reset_in low SHALL immediately clear rd_out and every memory word to 32'h0, independent of clk_in.
REQ-029 While reset_in is low, writes SHALL be blocked.
REQ-030 Normal operation SHALL resume on the first rising edge after reset_in goes high.
REQ-031 A write coincident with reset assertion SHALL be lost.

Structure
REQ-032 A shared package SHALL hold the load encodings (LD_WORD, LD_UBYTE, LD_SBYTE, LD_UHALF, LD_SHALF), the store encodings (ST_WORD, ST_BYTE, ST_HALF), and the constants DATA_W=32 and WE_W=4.
REQ-033 Load alignment and extension SHALL be a purely combinational sub-module, data_memory_load_align (inputs: word, addr[1:0], select; output: 32-bit result).

Verification
REQ-034 Reset then read addr 0x0 with select 000 -> rd_out = 0x00000000.
REQ-035 Write 0x80FF7F01 at 0x10 (we 1111, str 00), then read 0x13 with select 010 -> 0xFFFFFF80; select 001 -> 0x00000080.
REQ-036 Read 0x12 with select 100 -> 0xFFFF80FF; select 011 -> 0x000080FF.
REQ-037 Byte store wd 0x000000AB at 0x21 (str 01, we 0010) over 0x11223344, then word read -> 0x1122AB44.
REQ-038 Swap at 0x10 with wd 0xDEADBEEF, we 1111, swp 1 -> rd_out = 0x80FF7F01 next cycle; the following read returns 0xDEADBEEF.
REQ-039 Write without swp -> rd_out unchanged; mid-operation reset low -> rd_out = 0 asynchronously and all words read back 0.
